// File: rtl/pll_lock_sequencer_if.sv
// Signal bundle between the PLL lock sequencer and its surroundings.
// slave: the sequencer (samples PLL status and requests, drives resets/status).
// master: whatever drives the PLL status and relock requests and observes the results.
interface pll_lock_sequencer_if;
  logic       pll_locked;
  logic       relock_req;
  logic       pll_rst;
  logic       sys_rst;
  logic       ready;
  logic       fail;
  logic       lock_lost;
  logic [7:0] retry_cnt;
  logic [7:0] lock_loss_cnt;

  modport slave (
    input  pll_locked, relock_req,
    output pll_rst, sys_rst, ready, fail, lock_lost, retry_cnt, lock_loss_cnt
  );

  modport master (
    output pll_locked, relock_req,
    input  pll_rst, sys_rst, ready, fail, lock_lost, retry_cnt, lock_loss_cnt
  );
endinterface

// File: rtl/pll_lock_sequencer.sv
// PLL lock sequencer: pulses the PLL reset, waits for a stable lock, then
// releases the downstream reset. Retries on lock timeout, re-sequences on
// loss of lock or a relock request. Everything runs on refclk.
// Optional feature macro: LOCK_LOSS_CNT_EN (saturating lock-loss counter).
// All outputs are registered and derived from the next state, so they change
// in the same cycle the state register does.
module pll_lock_sequencer #(
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 50000,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int MAX_RETRIES         = 3,
  parameter int CNT_W               = 17
) (
  input  logic                  refclk,
  input  logic                  rst,
  pll_lock_sequencer_if.slave   bus
);

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAILED    = 3'd4
  } state_t;

  // Terminal counts: the counter starts at 0 on every transition, so a phase
  // lasting N cycles ends when the counter reads N-1.
  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [7:0]       RETRY_MAX   = 8'(MAX_RETRIES);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [7:0]       retry_reg, retry_next;
  logic             sync1_reg, locked_s_reg;
  logic             lock_lost_next;
  logic             pll_rst_reg, sys_rst_reg, ready_reg, fail_reg, lock_lost_reg;

  // Two-flop synchronizer for the asynchronous PLL locked flag.
  always_ff @(posedge refclk) begin
    if (rst) begin
      sync1_reg    <= 1'b0;
      locked_s_reg <= 1'b0;
    end else begin
      sync1_reg    <= bus.pll_locked;
      locked_s_reg <= sync1_reg;
    end
  end

  // Next-state, counter and retry decisions; relock_req overrides everything.
  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    retry_next     = retry_reg;
    lock_lost_next = 1'b0;
    if (bus.relock_req) begin
      state_next = RESET_PLL;
      cnt_next   = '0;
      retry_next = 8'd0;
    end else begin
      case (state_reg)
        RESET_PLL: begin
          if (cnt_reg == RST_LAST) begin
            state_next = WAIT_LOCK;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
        WAIT_LOCK: begin
          // A lock seen in the timeout cycle still counts as a lock.
          if (locked_s_reg) begin
            state_next = STABLE;
            cnt_next   = '0;
          end else if (cnt_reg == TIMEOUT_LAST) begin
            cnt_next = '0;
            if (retry_reg == RETRY_MAX) begin
              state_next = FAILED;
            end else begin
              state_next = RESET_PLL;
              retry_next = retry_reg + 8'd1;
            end
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
        STABLE: begin
          // Any dropout restarts the lock wait with a fresh timeout.
          if (!locked_s_reg) begin
            state_next = WAIT_LOCK;
            cnt_next   = '0;
          end else if (cnt_reg == STABLE_LAST) begin
            state_next = RUN;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
        RUN: begin
          if (!locked_s_reg) begin
            state_next     = RESET_PLL;
            cnt_next       = '0;
            retry_next     = 8'd0;
            lock_lost_next = 1'b1;
          end
        end
        FAILED: begin
          state_next = FAILED;
        end
        default: begin
          state_next = RESET_PLL;
          cnt_next   = '0;
          retry_next = 8'd0;
        end
      endcase
    end
  end

  // State, counters and registered outputs decoded from the next state.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_reg     <= RESET_PLL;
      cnt_reg       <= '0;
      retry_reg     <= 8'd0;
      pll_rst_reg   <= 1'b1;
      sys_rst_reg   <= 1'b1;
      ready_reg     <= 1'b0;
      fail_reg      <= 1'b0;
      lock_lost_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      retry_reg     <= retry_next;
      pll_rst_reg   <= (state_next == RESET_PLL) || (state_next == FAILED);
      sys_rst_reg   <= (state_next != RUN);
      ready_reg     <= (state_next == RUN);
      fail_reg      <= (state_next == FAILED);
      lock_lost_reg <= lock_lost_next;
    end
  end

  assign bus.pll_rst   = pll_rst_reg;
  assign bus.sys_rst   = sys_rst_reg;
  assign bus.ready     = ready_reg;
  assign bus.fail      = fail_reg;
  assign bus.lock_lost = lock_lost_reg;
  assign bus.retry_cnt = retry_reg;

`ifdef LOCK_LOSS_CNT_EN
  logic [7:0] loss_cnt_reg;

  // Saturating count of lock-loss events; only rst clears it.
  always_ff @(posedge refclk) begin
    if (rst) begin
      loss_cnt_reg <= 8'd0;
    end else if (lock_lost_next && (loss_cnt_reg != 8'hFF)) begin
      loss_cnt_reg <= loss_cnt_reg + 8'd1;
    end
  end

  assign bus.lock_loss_cnt = loss_cnt_reg;
`else
  assign bus.lock_loss_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Bench for pll_lock_sequencer: directed scenarios followed by random PLL
// lock behaviour; a phase-level reference model predicts outputs per cycle and
// a monitor compares them against the DUT.
module tb_pll_lock_sequencer;
  localparam int RP = 4;
  localparam int TO = 20;
  localparam int ST = 8;
  localparam int MR = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pll_lock_sequencer_if bus();

  pll_lock_sequencer #(
    .RST_PULSE_CYCLES(RP), .LOCK_TIMEOUT_CYCLES(TO),
    .LOCK_STABLE_CYCLES(ST), .MAX_RETRIES(MR), .CNT_W(17)
  ) dut (
    .refclk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic       pll_rst;
    logic       sys_rst;
    logic       ready;
    logic       fail;
    logic       lock_lost;
    logic [7:0] retry;
    logic [7:0] loss;
  } obs_t;

  typedef enum {PH_PULSE, PH_SEEK, PH_SETTLE, PH_LIVE, PH_DEAD} phase_t;

  // Reference model: which phase we are in and how many cycles were spent in it.
  phase_t ph;
  int     spent, retries, lost_n;
  bit     l1, l2, lost_flag;
  obs_t   exp_q[$];
  int     checks = 0;
  int     errors = 0;

  function void model_step(input bit r, input bit q, input bit l);
    bit ls;
    lost_flag = 1'b0;
    if (r) begin
      ph = PH_PULSE; spent = 0; retries = 0; lost_n = 0; l1 = 0; l2 = 0;
      return;
    end
    ls = l2;  // lock as seen after two synchronizer stages
    l2 = l1;
    l1 = l;
    if (q) begin
      ph = PH_PULSE; spent = 0; retries = 0;
      return;
    end
    case (ph)
      PH_PULSE: begin
        spent++;
        if (spent == RP) begin ph = PH_SEEK; spent = 0; end
      end
      PH_SEEK: begin
        if (ls) begin
          ph = PH_SETTLE; spent = 0;
        end else begin
          spent++;
          if (spent == TO) begin
            spent = 0;
            if (retries == MR) ph = PH_DEAD;
            else begin retries++; ph = PH_PULSE; end
          end
        end
      end
      PH_SETTLE: begin
        if (!ls) begin
          ph = PH_SEEK; spent = 0;
        end else begin
          spent++;
          if (spent == ST) begin ph = PH_LIVE; spent = 0; end
        end
      end
      PH_LIVE: begin
        if (!ls) begin
          lost_flag = 1'b1;
`ifdef LOCK_LOSS_CNT_EN
          if (lost_n < 255) lost_n++;
`endif
          retries = 0; ph = PH_PULSE; spent = 0;
        end
      end
      default: ;
    endcase
  endfunction

  function obs_t model_obs();
    obs_t o;
    o.pll_rst   = (ph == PH_PULSE) || (ph == PH_DEAD);
    o.sys_rst   = (ph != PH_LIVE);
    o.ready     = (ph == PH_LIVE);
    o.fail      = (ph == PH_DEAD);
    o.lock_lost = lost_flag;
    o.retry     = 8'(retries);
    o.loss      = 8'(lost_n);
    return o;
  endfunction

  // Drive one cycle of inputs on the falling edge and queue the prediction.
  task tick(input bit r, input bit q, input bit l);
    @(negedge clk);
    rst = r;
    bus.relock_req = q;
    bus.pll_locked = l;
    model_step(r, q, l);
    exp_q.push_back(model_obs());
  endtask

  task check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: after every active edge, compare DUT outputs with the oldest prediction.
  initial begin
    obs_t e, a;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {bus.pll_rst, bus.sys_rst, bus.ready, bus.fail, bus.lock_lost,
             bus.retry_cnt, bus.lock_loss_cnt};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL outputs t=%0t: got pll_rst=%0b sys_rst=%0b ready=%0b fail=%0b lock_lost=%0b retry=%0d loss=%0d, required pll_rst=%0b sys_rst=%0b ready=%0b fail=%0b lock_lost=%0b retry=%0d loss=%0d",
                   $time, a.pll_rst, a.sys_rst, a.ready, a.fail, a.lock_lost, a.retry, a.loss,
                   e.pll_rst, e.sys_rst, e.ready, e.fail, e.lock_lost, e.retry, e.loss);
        end
      end
    end
  end

  initial begin
    int hi, lat, pulses;
    bit got, l;
    bus.pll_locked = 1'b0;
    bus.relock_req = 1'b0;

    // Clean lock
    for (int i = 0; i < 3; i++) tick(1, 0, 0);
    hi = 0;
    for (int i = 0; i < 10; i++) begin
      tick(0, 0, 0);
      if (bus.pll_rst) hi++;
    end
    check("pll_rst_pulse_len", hi, RP);
    tick(0, 0, 1);
    lat = 0; got = 0;
    for (int j = 1; j <= 40; j++) begin
      tick(0, 0, 1);
      if (!got && bus.ready) begin lat = j; got = 1; end
    end
    // First sampling edge is one tick after the raise, then 2 sync + ST stable cycles.
    check("ready_latency", lat, 1 + 2 + ST);
    check("sys_rst_in_run", int'(bus.sys_rst), 0);
    check("retry_in_run", int'(bus.retry_cnt), 0);

    // Loss in RUN, then hold lock low until all retries time out
    pulses = 0;
    for (int i = 0; i < 98; i++) begin
      tick(0, 0, 0);
      if (bus.lock_lost) pulses++;
    end
    check("lock_lost_pulses", pulses, 1);
    check("fail_after_timeouts", int'(bus.fail), 1);
    check("pll_rst_in_failed", int'(bus.pll_rst), 1);
    check("ready_in_failed", int'(bus.ready), 0);
    check("retry_at_failure", int'(bus.retry_cnt), MR);
`ifdef LOCK_LOSS_CNT_EN
    check("loss_cnt", int'(bus.lock_loss_cnt), 1);
`else
    check("loss_cnt", int'(bus.lock_loss_cnt), 0);
`endif

    // Recovery from FAILED
    tick(0, 1, 0);
    tick(0, 0, 1);
    check("fail_cleared", int'(bus.fail), 0);
    check("retry_cleared", int'(bus.retry_cnt), 0);
    for (int i = 0; i < 40; i++) tick(0, 0, 1);
    check("ready_after_recovery", int'(bus.ready), 1);

    // Glitch during STABLE
    tick(0, 1, 1);
    for (int i = 0; i < 9; i++) tick(0, 0, 1);
    tick(0, 0, 0);
    for (int i = 0; i < 30; i++) tick(0, 0, 1);

    // relock_req coinciding with the second lock timeout
    tick(0, 1, 0);
    for (int i = 0; i < 47; i++) tick(0, 0, 0);
    tick(0, 1, 0);
    tick(0, 0, 0);
    check("retry_relock_priority", int'(bus.retry_cnt), 0);
    check("pll_rst_after_relock", int'(bus.pll_rst), 1);
    tick(1, 1, 1);
    tick(0, 0, 0);
    check("rst_over_relock_loss", int'(bus.lock_loss_cnt), 0);
    check("rst_over_relock_sys", int'(bus.sys_rst), 1);

    // Random lock behaviour with occasional relock requests and resets
    l = 0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 29) == 0) l = ~l;
      tick($urandom_range(0, 199) == 0, $urandom_range(0, 59) == 0, l);
    end

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL drain: got %0d pending predictions, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
